// File: rtl/ledcomm_sniffer.sv
// Receive-only Ledcomm decoder: samples a light sensor per base tick,
// classifies pulse lengths into bits/end markers and queues 16-bit words.
module ledcomm_sniffer #(
    parameter int FIFO_BITS     = 2,
    parameter int LINK_PULSES   = 18,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        light_in,
    input  logic [15:0] basiszeit,
    input  logic        rd,
    output logic [15:0] rx_data,
    output logic        valid,
    output logic        overflow,
    output logic        link_up,
    output logic [7:0]  glitch_count
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int DW    = $clog2(TIMEOUT_TICKS + 1);
    localparam int PW    = $clog2(LINK_PULSES + 1);
    localparam int AW    = FIFO_BITS + 1;

    localparam logic [DW-1:0] DARK_MAX = DW'(TIMEOUT_TICKS);
    localparam logic [DW-1:0] DARK_CLS = DW'(2);
    localparam logic [DW-1:0] DARK_ONE = DW'(1);
    localparam logic [PW-1:0] LINK_MAX = PW'(LINK_PULSES);
    localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   period_q, period_d;
    logic [3:0]    light_len_q, light_len_d;
    logic [DW-1:0] dark_len_q, dark_len_d;
    logic [15:0]   data_q, data_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [7:0]    glitch_q, glitch_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   mem_q [DEPTH];

    logic        tick;
    logic [15:0] last;
    logic        push;
    logic        good_ev;
    logic        glitch_ev;
    logic        timeout_ev;
    logic        full;
    logic        pop;
    logic        wr_en;

    // Base-time divider; the period is re-latched only when it wraps.
    always_comb begin
        sync1_d  = light_in;
        sync2_d  = sync1_q;
        tick     = (div_q == 16'd0);
        last     = tick ? basiszeit : period_q;
        period_d = last;
        if (last <= 16'd1 || div_q >= last - 16'd1) begin
            div_d = 16'd0;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    always_comb begin
        light_len_d = light_len_q;
        dark_len_d  = dark_len_q;
        data_d      = data_q;
        pulse_cnt_d = pulse_cnt_q;
        glitch_d    = glitch_q;
        push        = 1'b0;
        good_ev     = 1'b0;
        glitch_ev   = 1'b0;
        timeout_ev  = 1'b0;

        if (tick) begin
            if (sync2_q) begin
                dark_len_d = '0;
                if (dark_len_q == DARK_ONE && light_len_q != 4'd0) begin
                    glitch_ev   = 1'b1;
                    light_len_d = 4'd1;
                end else if (light_len_q != 4'd15) begin
                    light_len_d = light_len_q + 4'd1;
                end
            end else begin
                if (dark_len_q != DARK_MAX) begin
                    dark_len_d = dark_len_q + DW'(1);
                end
                if (dark_len_d == DARK_CLS && light_len_q != 4'd0) begin
                    light_len_d = 4'd0;
                    unique case (1'b1)
                        (light_len_q >= 4'd3 && light_len_q <= 4'd6): begin
                            data_d  = {data_q[14:0], 1'b1};
                            good_ev = 1'b1;
                        end
                        (light_len_q >= 4'd7 && light_len_q <= 4'd10): begin
                            data_d  = {data_q[14:0], 1'b0};
                            good_ev = 1'b1;
                        end
                        (light_len_q >= 4'd11 && light_len_q <= 4'd14): begin
                            push    = link_up;
                            data_d  = 16'd0;
                            good_ev = 1'b1;
                        end
                        default: glitch_ev = 1'b1;
                    endcase
                end
                timeout_ev = (dark_len_d == DARK_MAX);
            end
        end

        if (good_ev && pulse_cnt_q != LINK_MAX) begin
            pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
        if (glitch_ev) begin
            data_d      = 16'd0;
            pulse_cnt_d = '0;
            if (glitch_q != 8'hff) begin
                glitch_d = glitch_q + 8'd1;
            end
        end
        // Timeout wins over anything classified in the same tick.
        if (timeout_ev) begin
            pulse_cnt_d = '0;
            data_d      = 16'd0;
            light_len_d = 4'd0;
        end
    end

    always_comb begin
        valid = (wr_q != rd_q);
        full  = ((wr_q - rd_q) == FULL_CNT);
        pop   = rd && valid;
        wr_en = push && (!full || pop);
        ovf_d = ovf_q | (push && full && !pop);
        wr_d  = wr_q + AW'(wr_en);
        rd_d  = rd_q + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            div_q       <= 16'd0;
            period_q    <= 16'd0;
            light_len_q <= 4'd0;
            dark_len_q  <= '0;
            data_q      <= 16'd0;
            pulse_cnt_q <= '0;
            glitch_q    <= 8'd0;
            wr_q        <= '0;
            rd_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            div_q       <= div_d;
            period_q    <= period_d;
            light_len_q <= light_len_d;
            dark_len_q  <= dark_len_d;
            data_q      <= data_d;
            pulse_cnt_q <= pulse_cnt_d;
            glitch_q    <= glitch_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q[FIFO_BITS-1:0]] <= data_q;
        end
    end

    assign rx_data      = mem_q[rd_q[FIFO_BITS-1:0]];
    assign overflow     = ovf_q;
    assign link_up      = (pulse_cnt_q == LINK_MAX);
    assign glitch_count = glitch_q;

endmodule
